// File: rtl/riscv_div_issue_ctrl.sv
// riscv_div_issue_ctrl: issue/stall sequencer in front of the 64-bit iterative divider.
// Define RISCV_DIVCTL_FASTPATH_EN to resolve divide-by-zero and signed overflow without the divider.
module riscv_div_issue_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        i_riscv_divctl_clk,
    input  logic        i_riscv_divctl_rst,
    input  logic        i_riscv_divctl_valid,
    input  logic [1:0]  i_riscv_divctl_op,
    input  logic        i_riscv_divctl_word,
    input  logic [63:0] i_riscv_divctl_rs1data,
    input  logic [63:0] i_riscv_divctl_rs2data,
    input  logic        i_riscv_divctl_flush,
    input  logic [63:0] i_riscv_divctl_div_result,
    input  logic        i_riscv_divctl_div_valid,
    output logic [2:0]  o_riscv_divctl_divctrl,
    output logic [63:0] o_riscv_divctl_rs1data,
    output logic [63:0] o_riscv_divctl_rs2data,
    output logic [63:0] o_riscv_divctl_result,
    output logic        o_riscv_divctl_result_valid,
    output logic        o_riscv_divctl_stall,
    output logic        o_riscv_divctl_err
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]  r_state, r_op;
    logic        r_word, r_discard, r_fast, r_err;
    logic [7:0]  r_wd;
    logic [63:0] r_rs1, r_rs2, r_result;
    logic        w_accept, w_signed, w_wait, w_timeout, w_kill, w_fast;
    logic [63:0] w_rs1, w_rs2, w_fmt, w_fast_res;

    assign w_accept  = r_state == S_IDLE && i_riscv_divctl_valid && !i_riscv_divctl_flush;
    assign w_signed  = !i_riscv_divctl_op[0];
    assign w_rs1     = i_riscv_divctl_word ? {{32{w_signed & i_riscv_divctl_rs1data[31]}}, i_riscv_divctl_rs1data[31:0]}
                                           : i_riscv_divctl_rs1data;
    assign w_rs2     = i_riscv_divctl_word ? {{32{w_signed & i_riscv_divctl_rs2data[31]}}, i_riscv_divctl_rs2data[31:0]}
                                           : i_riscv_divctl_rs2data;
    assign w_fmt     = r_word ? {{32{i_riscv_divctl_div_result[31]}}, i_riscv_divctl_div_result[31:0]}
                              : i_riscv_divctl_div_result;
    assign w_wait    = r_state == S_RUN || r_state == S_DRAIN;
    assign w_timeout = w_wait && !i_riscv_divctl_div_valid && r_wd == 8'(TIMEOUT_CYCLES - 1);
    assign w_kill    = r_discard || i_riscv_divctl_flush;

`ifdef RISCV_DIVCTL_FASTPATH_EN
    logic w_zero, w_ovf;
    assign w_zero     = i_riscv_divctl_word ? i_riscv_divctl_rs2data[31:0] == 32'd0 : i_riscv_divctl_rs2data == 64'd0;
    assign w_ovf      = w_signed && &w_rs2 &&
                        w_rs1 == (i_riscv_divctl_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000);
    assign w_fast     = w_zero || w_ovf;
    // On overflow the prepared dividend already is INT_MIN of the active width.
    assign w_fast_res = w_zero ? (i_riscv_divctl_op[1] ? (i_riscv_divctl_word ? {{32{w_rs1[31]}}, w_rs1[31:0]} : w_rs1) : '1)
                               : (i_riscv_divctl_op[1] ? '0 : w_rs1);
`else
    assign w_fast     = 1'b0;
    assign w_fast_res = '0;
`endif

    always_ff @(posedge i_riscv_divctl_clk) begin
        if (i_riscv_divctl_rst) begin
            r_state   <= S_IDLE;
            r_op      <= '0;
            r_word    <= 1'b0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_result  <= '0;
            r_discard <= 1'b0;
            r_fast    <= 1'b0;
            r_err     <= 1'b0;
            r_wd      <= '0;
        end else begin
            r_err <= w_timeout;
            if (w_wait && !i_riscv_divctl_div_valid) r_wd <= r_wd + 8'd1;
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_op     <= i_riscv_divctl_op;
                    r_word   <= i_riscv_divctl_word;
                    r_rs1    <= w_rs1;
                    r_rs2    <= w_rs2;
                    r_fast   <= w_fast;
                    r_result <= w_fast_res;
                    r_wd     <= '0;
                    r_state  <= w_fast ? S_DONE : S_RUN;
                end
                S_RUN: begin
                    if (i_riscv_divctl_div_valid) begin
                        if (!w_kill) r_result <= w_fmt;
                        r_wd    <= '0;
                        r_state <= w_kill ? S_DRAIN : S_DONE;
                    end else if (w_timeout) begin
                        r_discard <= 1'b0;
                        r_state   <= S_IDLE;
                    end else if (i_riscv_divctl_flush) begin
                        r_discard <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_wd    <= '0;
                    r_state <= r_fast ? S_IDLE : S_DRAIN;
                end
                S_DRAIN: if (i_riscv_divctl_div_valid || w_timeout) begin
                    r_discard <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    // Start stays high through the valid cycle, which makes the divider rerun once; DRAIN absorbs that run.
    assign o_riscv_divctl_divctrl      = {r_state == S_RUN, r_op};
    assign o_riscv_divctl_rs1data      = r_rs1;
    assign o_riscv_divctl_rs2data      = r_rs2;
    assign o_riscv_divctl_result       = r_result;
    assign o_riscv_divctl_result_valid = r_state == S_DONE;
    assign o_riscv_divctl_stall        = i_riscv_divctl_valid && !i_riscv_divctl_flush && r_state != S_DONE;
    assign o_riscv_divctl_err          = r_err;
endmodule
